// File: rtl/tm1638_display_sequencer.sv
// Purpose : snapshots eight 7-seg patterns and serialises the full TM1638 write (mode, addr+data, display ctrl).
// Latency : busy/stb assert on the edge that samples update; done pulses 310*CLK_DIV cycles later.
// Backpre.: update while busy merges into one pending request, replayed directly from the last frame gap.
//
// Ports:
//   _50MHz_CLK            system clock (rising edge)
//   rst                   synchronous active-high reset
//   update                refresh request, sampled every cycle
//   LED7SEG_0..LED7SEG_7  segment patterns, bit 0 shifted first
//   busy                  transaction in progress
//   done                  one-cycle completion pulse
//   clk, stb, dio         TM1638 serial pins (clk idles high, stb active low, dio write-only)
module tm1638_display_sequencer #(
  parameter int         CLK_DIV    = 25,
  parameter logic [2:0] BRIGHTNESS = 3'd7
) (
  input  logic       _50MHz_CLK,
  input  logic       rst,
  input  logic       update,
  input  logic [7:0] LED7SEG_0,
  input  logic [7:0] LED7SEG_1,
  input  logic [7:0] LED7SEG_2,
  input  logic [7:0] LED7SEG_3,
  input  logic [7:0] LED7SEG_4,
  input  logic [7:0] LED7SEG_5,
  input  logic [7:0] LED7SEG_6,
  input  logic [7:0] LED7SEG_7,
  output logic       busy,
  output logic       done,
  output logic       clk,
  output logic       stb,
  output logic       dio
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    STB_SETUP,
    SHIFT_LO,
    SHIFT_HI,
    STB_GAP
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    bit_q, bit_n;
  logic [4:0]    byte_q, byte_n;
  logic [1:0]    frame_q, frame_n;
  logic [63:0]   snap_q, snap_n;
  logic          pending_q, pending_n;

  logic          clk_n, stb_n, dio_n, busy_n, done_n;
  logic          phase_end;
  logic          last_byte;
  logic          start;
  logic [7:0]    cur_byte_n;

  // Byte b of frame f. Frame 1 (index 1) interleaves digit patterns at even
  // addresses with zeros for the discrete LEDs at odd addresses.
  function automatic logic [7:0] frame_byte(input logic [1:0]  f,
                                            input logic [4:0]  b,
                                            input logic [63:0] s);
    logic [2:0] digit;
    digit      = 3'((b - 5'd1) >> 1);
    frame_byte = 8'h00;
    case (f)
      2'd0:    frame_byte = 8'h40;
      2'd1: begin
        if (b == 5'd0)
          frame_byte = 8'hC0;
        else if (b[0])
          frame_byte = s[{digit, 3'b000} +: 8];
        else
          frame_byte = 8'h00;
      end
      default: frame_byte = 8'h88 | {5'b00000, BRIGHTNESS};
    endcase
  endfunction

  assign phase_end = (cnt_q == CNT_LAST);
  assign last_byte = (frame_q == 2'd1) ? (byte_q == 5'd16) : 1'b1;

  always_ff @(posedge _50MHz_CLK) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = phase_end ? '0 : cnt_q + CW'(1);
    bit_n     = bit_q;
    byte_n    = byte_q;
    frame_n   = frame_q;
    snap_n    = snap_q;
    pending_n = pending_q;
    done_n    = 1'b0;
    start     = 1'b0;

    if (state_q != IDLE && update)
      pending_n = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (update)
          start = 1'b1;
      end
      STB_SETUP: begin
        if (phase_end)
          state_n = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_end)
          state_n = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_end) begin
          if (bit_q != 3'd7) begin
            bit_n   = bit_q + 3'd1;
            state_n = SHIFT_LO;
          end else if (!last_byte) begin
            bit_n   = 3'd0;
            byte_n  = byte_q + 5'd1;
            state_n = SHIFT_LO;
          end else begin
            state_n = STB_GAP;
          end
        end
      end
      STB_GAP: begin
        if (phase_end) begin
          if (frame_q == 2'd2) begin
            done_n = 1'b1;
            // A request seen on this final edge counts as merged as well.
            if (pending_q || update)
              start = 1'b1;
            else
              state_n = IDLE;
          end else begin
            frame_n = frame_q + 2'd1;
            byte_n  = 5'd0;
            bit_n   = 3'd0;
            state_n = STB_SETUP;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      snap_n    = {LED7SEG_7, LED7SEG_6, LED7SEG_5, LED7SEG_4,
                   LED7SEG_3, LED7SEG_2, LED7SEG_1, LED7SEG_0};
      state_n   = STB_SETUP;
      frame_n   = 2'd0;
      byte_n    = 5'd0;
      bit_n     = 3'd0;
      cnt_n     = '0;
      pending_n = 1'b0;
    end

    // Pin values are registered from the next state so each phase change
    // moves clk/stb/dio together on one edge, glitch-free.
    cur_byte_n = frame_byte(frame_n, byte_n, snap_n);
    clk_n      = (state_n != SHIFT_LO);
    stb_n      = !(state_n == STB_SETUP || state_n == SHIFT_LO || state_n == SHIFT_HI);
    dio_n      = (state_n == SHIFT_LO || state_n == SHIFT_HI) ? cur_byte_n[bit_n] : 1'b1;
    busy_n     = (state_n != IDLE);
  end

  always_ff @(posedge _50MHz_CLK) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      frame_q   <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      clk       <= 1'b1;
      stb       <= 1'b1;
      dio       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt_q     <= cnt_n;
      bit_q     <= bit_n;
      byte_q    <= byte_n;
      frame_q   <= frame_n;
      snap_q    <= snap_n;
      pending_q <= pending_n;
      clk       <= clk_n;
      stb       <= stb_n;
      dio       <= dio_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_tm1638_display_sequencer.sv
module tb_tm1638_display_sequencer;

  logic       sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       rst;
  logic       update;
  logic [7:0] leds [8];
  logic       busy, done, ser_clk, stb, dio;

  tm1638_display_sequencer #(.CLK_DIV(2), .BRIGHTNESS(3'd7)) dut (
    ._50MHz_CLK(sys_clk),
    .rst       (rst),
    .update    (update),
    .LED7SEG_0 (leds[0]),
    .LED7SEG_1 (leds[1]),
    .LED7SEG_2 (leds[2]),
    .LED7SEG_3 (leds[3]),
    .LED7SEG_4 (leds[4]),
    .LED7SEG_5 (leds[5]),
    .LED7SEG_6 (leds[6]),
    .LED7SEG_7 (leds[7]),
    .busy      (busy),
    .done      (done),
    .clk       (ser_clk),
    .stb       (stb),
    .dio       (dio)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Scoreboard: expected bytes and per-frame byte counts.
  logic [7:0] exp_q [$];
  int         len_q [$];

  // Serial decoder state.
  int         bit_cnt     = 0;
  int         frame_bytes = 0;
  logic [7:0] sh          = 8'h00;
  logic       prev_clk    = 1'b1;
  logic       prev_stb    = 1'b1;
  int         hi_run      = 0;
  int         last_hi_run = 0;
  bit         stb_fell    = 1'b0;
  int         done_cnt    = 0;
  int         done_cyc    = 0;

  task automatic push_txn(input logic [7:0] p [8]);
    exp_q.push_back(8'h40);
    len_q.push_back(1);
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(p[i]);
      exp_q.push_back(8'h00);
    end
    len_q.push_back(17);
    exp_q.push_back(8'h88 | 8'h07);
    len_q.push_back(1);
  endtask

  task automatic monitor();
    logic [7:0] e;
    int         el;
    stb_fell = 1'b0;
    if (rst) begin
      bit_cnt     = 0;
      frame_bytes = 0;
      prev_clk    = 1'b1;
      prev_stb    = 1'b1;
      hi_run      = 0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!stb && ser_clk && !prev_clk) begin
        sh[bit_cnt] = dio;
        bit_cnt++;
        if (bit_cnt == 8) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL byte: got %h at cycle %0d, scoreboard empty", sh, cyc);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e) begin
              fails++;
              $display("FAIL byte: got %h, expected %h at cycle %0d", sh, e, cyc);
            end
          end
          frame_bytes++;
          bit_cnt = 0;
        end
      end
      if (stb && !prev_stb) begin
        tests++;
        el = (len_q.size() != 0) ? len_q.pop_front() : -1;
        if (frame_bytes !== el || bit_cnt != 0) begin
          fails++;
          $display("FAIL frame_len: got %0d bytes + %0d bits, expected %0d bytes", frame_bytes, bit_cnt, el);
        end
        frame_bytes = 0;
        bit_cnt     = 0;
      end
      if (!stb && prev_stb) begin
        stb_fell    = 1'b1;
        last_hi_run = hi_run;
        hi_run      = 0;
      end
      if (stb) hi_run++;
      prev_clk = ser_clk;
      prev_stb = stb;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drained: %0d bytes / %0d frames left, expected 0/0", name, exp_q.size(), len_q.size());
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    update = 1'b0;
    for (int i = 0; i < 8; i++) leds[i] = 8'h00;
    repeat (3) tick();
    tests++;
    if ({ser_clk, stb, dio, busy, done} !== 5'b11100) begin
      fails++;
      $display("FAIL reset_values: clk/stb/dio/busy/done = %b, expected 11100", {ser_clk, stb, dio, busy, done});
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      tests++;
      if ({ser_clk, stb, dio, busy, done} !== 5'b11100) begin
        fails++;
        $display("FAIL idle_pins: cycle %0d got %b, expected 11100", i, {ser_clk, stb, dio, busy, done});
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] p [8];
    int         e_cyc;
    bit         ok;
    p = '{8'hDA, 8'hDA, 8'hB7, 8'hB7, 8'hDA, 8'hDA, 8'hFA, 8'hDA};
    leds = p;
    push_txn(p);
    update = 1'b1;
    tick();
    e_cyc  = cyc;
    update = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_start: got %b, expected 1", busy);
    end
    wait_done(1000, ok);
    tests++;
    if (done_cyc !== e_cyc + 620) begin
      fails++;
      $display("FAIL done_latency: got %0d cycles, expected 620", done_cyc - e_cyc);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_end: got %b, expected 0", busy);
    end
    check_drained("basic");
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_width: got %b one cycle later, expected 0", done);
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] p [8];
    bit         ok;
    p = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    leds = p;
    push_txn(p);
    update = 1'b1;
    tick();
    update = 1'b0;
    for (int i = 0; i < 8; i++) leds[i] = 8'hFF;
    wait_done(1000, ok);
    check_drained("snapshot");
    repeat (5) tick();
  endtask

  task automatic test_pending();
    logic [7:0] pa [8];
    logic [7:0] pb [8];
    int         e_cyc, start, first_done;
    bit         busy_drop;
    pa = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    pb = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h0F, 8'hF0, 8'h99, 8'h66};
    leds = pa;
    push_txn(pa);
    push_txn(pb);
    start      = done_cnt;
    first_done = -1;
    busy_drop  = 1'b0;
    update = 1'b1;
    tick();
    e_cyc  = cyc;
    update = 1'b0;
    for (int i = 1; i < 2000 && (done_cnt - start) < 2; i++) begin
      if (i == 100 || i == 200 || i == 300) update = 1'b1;
      if (i == 400) leds = pb;
      tick();
      update = 1'b0;
      if (first_done < 0 && (done_cnt - start) == 1) first_done = done_cyc;
      if ((done_cnt - start) < 2 && busy !== 1'b1) busy_drop = 1'b1;
    end
    tests++;
    if (busy_drop) begin
      fails++;
      $display("FAIL pending_busy: busy dropped between transactions, expected continuously 1");
    end
    tests++;
    if (first_done !== e_cyc + 620) begin
      fails++;
      $display("FAIL pending_done1: got cycle offset %0d, expected 620", first_done - e_cyc);
    end
    tests++;
    if (done_cyc !== e_cyc + 1240) begin
      fails++;
      $display("FAIL pending_done2: got cycle offset %0d, expected 1240", done_cyc - e_cyc);
    end
    repeat (100) tick();
    tests++;
    if (done_cnt - start !== 2) begin
      fails++;
      $display("FAIL pending_count: got %0d done pulses, expected 2", done_cnt - start);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL pending_idle: busy got %b, expected 0", busy);
    end
    check_drained("pending");
  endtask

  task automatic test_midreset();
    logic [7:0] pc [8];
    logic [7:0] pd [8];
    int         e_cyc;
    bit         ok;
    pc = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pd = '{8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78};
    leds = pc;
    push_txn(pc);
    update = 1'b1;
    tick();
    update = 1'b0;
    repeat (150) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({stb, ser_clk, busy} !== 3'b110) begin
      fails++;
      $display("FAIL midreset_pins: stb/clk/busy got %b, expected 110", {stb, ser_clk, busy});
    end
    exp_q.delete();
    len_q.delete();
    repeat (5) tick();
    leds = pd;
    push_txn(pd);
    update = 1'b1;
    tick();
    e_cyc  = cyc;
    update = 1'b0;
    wait_done(1000, ok);
    tests++;
    if (done_cyc !== e_cyc + 620) begin
      fails++;
      $display("FAIL midreset_latency: got %0d cycles, expected 620", done_cyc - e_cyc);
    end
    check_drained("midreset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] pe [8];
    int         start, falls;
    pe = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70};
    leds = pe;
    push_txn(pe);
    push_txn(pe);
    start  = done_cnt;
    falls  = 0;
    update = 1'b1;
    for (int i = 0; i < 3000 && (done_cnt - start) < 2; i++) begin
      tick();
      if ((done_cnt - start) >= 1) update = 1'b0;
      if (stb_fell) begin
        if (falls > 0) begin
          tests++;
          if (last_hi_run !== 2) begin
            fails++;
            $display("FAIL gap_width: stb high %0d cycles before fall %0d, expected 2", last_hi_run, falls);
          end
        end
        falls++;
      end
    end
    update = 1'b0;
    repeat (50) tick();
    tests++;
    if (falls !== 6) begin
      fails++;
      $display("FAIL b2b_frames: got %0d stb windows, expected 6", falls);
    end
    tests++;
    if (done_cnt - start !== 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d done pulses, expected 2", done_cnt - start);
    end
    check_drained("b2b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_pending();
    test_midreset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
